move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer_if.sv | 35 +++
 rtl/move_sequencer.sv | 179 +++++++++++++++++
 tb/tb_move_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// Handshake bundle between the move sequencer and the board engine.
// master: sequencer (drives move_req/move_dir/spawn_req).
// slave: board engine (drives move_ack/move_done/move_changed/spawn_done).

interface move_sequencer_if;

    logic       move_req;
    logic [1:0] move_dir;
    logic       move_ack;
    logic       move_done;
    logic       move_changed;
    logic       spawn_req;
    logic       spawn_done;

    modport master (
        output move_req,
        output move_dir,
        output spawn_req,
        input  move_ack,
        input  move_done,
        input  move_changed,
        input  spawn_done
    );

    modport slave (
        input  move_req,
        input  move_dir,
        input  spawn_req,
        output move_ack,
        output move_done,
        output move_changed,
        output spawn_done
    );

endinterface

// File: rtl/move_sequencer.sv
// Joystick move sequencer: debounces centre/direction codes and runs
// one move transaction (request, execute, optional tile spawn) per
// qualified direction.
// Ports:
//   clk, rst        clock, async active-high reset
//   dir             joystick code (000 up .. 011 left, 1xx centre)
//   game_over       blocks qualification of new moves
//   clr_count       synchronous clear of move_count
//   bus             board engine handshake (master side)
//   busy            transaction in flight (REQ/EXEC/SPAWN)
//   move_count      saturating count of board-changing moves

module move_sequencer #(
    parameter logic [19:0] STABLE_CYCLES = 20'd1000000,
    parameter bit          SPAWN_EN      = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          dir,
    input  logic                game_over,
    input  logic                clr_count,
    move_sequencer_if.master    bus,
    output logic                busy,
    output logic [15:0]         move_count
);

    typedef enum logic [2:0] {
        ST_WAIT_CENTER,
        ST_WAIT_DIR,
        ST_QUALIFY,
        ST_REQ,
        ST_EXEC,
        ST_SPAWN
    } state_t;

    localparam logic [19:0] LAST_CNT = STABLE_CYCLES - 20'd1;

    state_t      state_q,      state_d;
    logic [19:0] cnt_q,        cnt_d;
    logic [1:0]  cand_q,       cand_d;
    logic        move_req_q,   move_req_d;
    logic [1:0]  move_dir_q,   move_dir_d;
    logic        spawn_req_q,  spawn_req_d;
    logic        busy_q,       busy_d;
    logic [15:0] move_count_q, move_count_d;

    logic        dir_centre;
    logic        dir_valid;
    logic        take_done;
    logic        count_inc;

    // Codes 100..111 all count as centre.
    assign dir_centre = dir[2];
    assign dir_valid  = ~dir[2] & ~game_over;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        move_req_d  = move_req_q;
        move_dir_d  = move_dir_q;
        spawn_req_d = spawn_req_q;
        take_done   = 1'b0;
        count_inc   = 1'b0;

        unique case (state_q)
            ST_WAIT_CENTER: begin
                if (!dir_centre) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DIR;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            ST_WAIT_DIR: begin
                if (dir_valid) begin
                    cand_d  = dir[1:0];
                    cnt_d   = '0;
                    state_d = ST_QUALIFY;
                end
            end

            ST_QUALIFY: begin
                if (dir != {1'b0, cand_q} || game_over) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DIR;
                end else if (cnt_q == LAST_CNT) begin
                    // Counter restarts so the next centre
                    // qualification begins from zero.
                    cnt_d      = '0;
                    move_dir_d = cand_q;
                    move_req_d = 1'b1;
                    state_d    = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            ST_REQ: begin
                if (bus.move_ack) begin
                    move_req_d = 1'b0;
                    state_d    = ST_EXEC;
                    // Ack and done together skip EXEC entirely.
                    take_done  = bus.move_done;
                end
            end

            ST_EXEC: begin
                take_done = bus.move_done;
            end

            ST_SPAWN: begin
                if (bus.spawn_done) begin
                    spawn_req_d = 1'b0;
                    state_d     = ST_WAIT_CENTER;
                end
            end

            default: begin
                state_d = ST_WAIT_CENTER;
            end
        endcase

        if (take_done) begin
            state_d = ST_WAIT_CENTER;
            if (bus.move_changed) begin
                count_inc = 1'b1;
                if (SPAWN_EN) begin
                    spawn_req_d = 1'b1;
                    state_d     = ST_SPAWN;
                end
            end
        end

        busy_d = (state_d == ST_REQ)  ||
                 (state_d == ST_EXEC) ||
                 (state_d == ST_SPAWN);

        if (clr_count) begin
            move_count_d = '0;
        end else if (count_inc && move_count_q != 16'hFFFF) begin
            move_count_d = move_count_q + 16'd1;
        end else begin
            move_count_d = move_count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT_CENTER;
            cnt_q        <= '0;
            cand_q       <= '0;
            move_req_q   <= 1'b0;
            move_dir_q   <= '0;
            spawn_req_q  <= 1'b0;
            busy_q       <= 1'b0;
            move_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            move_req_q   <= move_req_d;
            move_dir_q   <= move_dir_d;
            spawn_req_q  <= spawn_req_d;
            busy_q       <= busy_d;
            move_count_q <= move_count_d;
        end
    end

    assign bus.move_req  = move_req_q;
    assign bus.move_dir  = move_dir_q;
    assign bus.spawn_req = spawn_req_q;
    assign busy          = busy_q;
    assign move_count    = move_count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer (STABLE_CYCLES=4, SPAWN_EN=1).
// Vector table, directed corner sequences and random stimulus vs model.

module tb_move_sequencer;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dir = 3'd4;
    logic       go  = 1'b0;
    logic       clr = 1'b0;
    logic       ack = 1'b0;
    logic       done = 1'b0;
    logic       chg = 1'b0;
    logic       sd  = 1'b0;
    logic       busy;
    logic [15:0] move_count;

    move_sequencer_if bus ();

    assign bus.move_ack     = ack;
    assign bus.move_done    = done;
    assign bus.move_changed = chg;
    assign bus.spawn_done   = sd;

    move_sequencer #(
        .STABLE_CYCLES (20'd4),
        .SPAWN_EN      (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dir        (dir),
        .game_over  (go),
        .clr_count  (clr),
        .bus        (bus),
        .busy       (busy),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit req_seen;
    int rand_moves;

    // Behavioural model built on run lengths of input codes.
    bit         m_armed;
    int         m_crun;
    int         m_run;
    logic [1:0] m_rdir;
    bit         m_inreq, m_inexec, m_inspawn;
    logic [1:0] m_md;
    int         m_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_armed = 0; m_crun = 0; m_run = 0; m_rdir = 2'd0;
        m_inreq = 0; m_inexec = 0; m_inspawn = 0;
        m_md = 2'd0; m_cnt = 0;
    endtask

    task automatic model_finish();
        if (chg) begin
            if (m_cnt < 65535) m_cnt++;
            m_inspawn = 1;
        end
    endtask

    task automatic model_edge();
        bit valid;
        if (rst) begin
            model_reset();
        end else begin
            valid = !dir[2] && !go;
            if (m_inreq) begin
                if (ack) begin
                    m_inreq = 0;
                    if (done) model_finish();
                    else m_inexec = 1;
                end
            end else if (m_inexec) begin
                if (done) begin
                    m_inexec = 0;
                    model_finish();
                end
            end else if (m_inspawn) begin
                if (sd) m_inspawn = 0;
            end else if (!m_armed) begin
                if (dir[2]) begin
                    m_crun++;
                    if (m_crun == S) begin
                        m_armed = 1;
                        m_run = 0;
                    end
                end else begin
                    m_crun = 0;
                end
            end else if (m_run == 0) begin
                if (valid) begin
                    m_rdir = dir[1:0];
                    m_run = 1;
                end
            end else if (valid && dir[1:0] == m_rdir) begin
                m_run++;
                if (m_run == S + 1) begin
                    m_inreq = 1;
                    m_md = m_rdir;
                    m_armed = 0;
                    m_crun = 0;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (clr) m_cnt = 0;
        end
    endtask

    task automatic model_cmp();
        chk("move_req", {31'd0, bus.move_req}, {31'd0, m_inreq});
        chk("move_dir", {30'd0, bus.move_dir}, {30'd0, m_md});
        chk("spawn_req", {31'd0, bus.spawn_req}, {31'd0, m_inspawn});
        chk("busy", {31'd0, busy},
            {31'd0, (m_inreq | m_inexec | m_inspawn)});
        chk("move_count", {16'd0, move_count}, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_cmp();
        if (bus.move_req) req_seen = 1;
    endtask

    task automatic hold(input logic [2:0] d, input int n);
        dir = d;
        repeat (n) step();
    endtask

    typedef struct {
        int         n;
        logic [2:0] dir;
        logic       ack, done, chg, sd, clr;
        logic       e_req;
        logic [1:0] e_md;
        logic       e_sp, e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n, logic [2:0] d, logic a, logic dn,
                                logic c, logic s, logic cl, logic er,
                                logic [1:0] em, logic es, logic eb,
                                logic [15:0] ec);
        vec_t v;
        v.n = n; v.dir = d; v.ack = a; v.done = dn; v.chg = c;
        v.sd = s; v.clr = cl; v.e_req = er; v.e_md = em;
        v.e_sp = es; v.e_busy = eb; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        model_reset();
        //            n dir ack dn chg sd clr req md sp busy cnt
        tbl.push_back(mk(4, 3'd4, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 16'd0));
        tbl.push_back(mk(4, 3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 16'd0));
        tbl.push_back(mk(1, 3'd1, 0, 0, 0, 0, 0, 1, 2'd1, 0, 1, 16'd0));
        tbl.push_back(mk(2, 3'd1, 0, 0, 0, 0, 0, 1, 2'd1, 0, 1, 16'd0));
        tbl.push_back(mk(1, 3'd1, 1, 0, 0, 0, 0, 0, 2'd1, 0, 1, 16'd0));
        tbl.push_back(mk(1, 3'd1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 1, 16'd0));
        tbl.push_back(mk(1, 3'd1, 0, 1, 1, 0, 0, 0, 2'd1, 1, 1, 16'd1));
        tbl.push_back(mk(2, 3'd1, 0, 0, 0, 0, 0, 0, 2'd1, 1, 1, 16'd1));
        tbl.push_back(mk(1, 3'd1, 0, 0, 0, 1, 0, 0, 2'd1, 0, 0, 16'd1));
        tbl.push_back(mk(5, 3'd0, 0, 1, 1, 1, 0, 0, 2'd1, 0, 0, 16'd1));
        tbl.push_back(mk(4, 3'd6, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 16'd1));
        tbl.push_back(mk(4, 3'd2, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 16'd1));
        tbl.push_back(mk(1, 3'd2, 0, 0, 0, 0, 0, 1, 2'd2, 0, 1, 16'd1));
        tbl.push_back(mk(1, 3'd2, 1, 1, 0, 0, 0, 0, 2'd2, 0, 0, 16'd1));
        tbl.push_back(mk(1, 3'd4, 0, 0, 0, 0, 1, 0, 2'd2, 0, 0, 16'd0));

        #12;
        chk("rst_req", {31'd0, bus.move_req}, 32'd0);
        chk("rst_spawn", {31'd0, bus.spawn_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, move_count}, 32'd0);
        chk("rst_dir", {30'd0, bus.move_dir}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table
        foreach (tbl[i]) begin
            dir = tbl[i].dir; ack = tbl[i].ack; done = tbl[i].done;
            chg = tbl[i].chg; sd = tbl[i].sd; clr = tbl[i].clr;
            for (int k = 0; k < tbl[i].n; k++) begin
                step();
                chk($sformatf("tbl%0d_req", i),
                    {31'd0, bus.move_req}, {31'd0, tbl[i].e_req});
                chk($sformatf("tbl%0d_dir", i),
                    {30'd0, bus.move_dir}, {30'd0, tbl[i].e_md});
                chk($sformatf("tbl%0d_spawn", i),
                    {31'd0, bus.spawn_req}, {31'd0, tbl[i].e_sp});
                chk($sformatf("tbl%0d_busy", i),
                    {31'd0, busy}, {31'd0, tbl[i].e_busy});
                chk($sformatf("tbl%0d_cnt", i),
                    {16'd0, move_count}, {16'd0, tbl[i].e_cnt});
            end
        end
        ack = 0; done = 0; chg = 0; sd = 0; clr = 0;

        // Held direction gives a single move
        hold(3'd4, 4);
        hold(3'd0, 5);
        chk("a_req", {31'd0, bus.move_req}, 32'd1);
        chk("a_dir", {30'd0, bus.move_dir}, 32'd0);
        ack = 1; done = 1; chg = 1; step();
        ack = 0; done = 0; chg = 0;
        chk("a_spawn", {31'd0, bus.spawn_req}, 32'd1);
        sd = 1; step(); sd = 0;
        chk("a_cnt", {16'd0, move_count}, 32'd1);
        req_seen = 0;
        hold(3'd0, 100);
        chk("a_held_no_req", {31'd0, req_seen}, 32'd0);
        hold(3'd4, 4);
        hold(3'd2, 5);
        chk("a_req2", {31'd0, bus.move_req}, 32'd1);
        chk("a_dir2", {30'd0, bus.move_dir}, 32'd2);
        ack = 1; step(); ack = 0;
        done = 1; chg = 0; step(); done = 0;
        chk("a_nospawn", {31'd0, bus.spawn_req}, 32'd0);
        chk("a_cnt_same", {16'd0, move_count}, 32'd1);
        chk("a_idle", {31'd0, busy}, 32'd0);

        // Direction glitch during qualification
        hold(3'd4, 4);
        req_seen = 0;
        hold(3'd0, 2);
        hold(3'd1, 1);
        hold(3'd0, 4);
        chk("b_glitch_no_req", {31'd0, req_seen}, 32'd0);
        hold(3'd0, 1);
        chk("b_req", {31'd0, bus.move_req}, 32'd1);
        ack = 1; step(); ack = 0;
        done = 1; chg = 1; clr = 1; step();
        done = 0; chg = 0; clr = 0;
        chk("b_clr_wins", {16'd0, move_count}, 32'd0);
        chk("b_spawn", {31'd0, bus.spawn_req}, 32'd1);
        sd = 1; step(); sd = 0;

        // game_over blocks qualification but not a transaction
        hold(3'd4, 4);
        hold(3'd3, 2);
        go = 1; req_seen = 0;
        hold(3'd3, 6);
        chk("g_no_req", {31'd0, req_seen}, 32'd0);
        go = 0;
        hold(3'd3, 4);
        chk("g_pending", {31'd0, bus.move_req}, 32'd0);
        hold(3'd3, 1);
        chk("g_req", {31'd0, bus.move_req}, 32'd1);
        chk("g_dir", {30'd0, bus.move_dir}, 32'd3);
        go = 1; ack = 1; step(); ack = 0;
        chk("g_busy_exec", {31'd0, busy}, 32'd1);
        done = 1; chg = 1; step(); done = 0; chg = 0;
        chk("g_spawn", {31'd0, bus.spawn_req}, 32'd1);
        chk("g_cnt", {16'd0, move_count}, 32'd1);
        go = 0;

        // Asynchronous reset while spawn_req is high
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("d_spawn_drop", {31'd0, bus.spawn_req}, 32'd0);
        chk("d_cnt", {16'd0, move_count}, 32'd0);
        chk("d_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        req_seen = 0;
        hold(3'd1, 12);
        chk("d_need_centre", {31'd0, req_seen}, 32'd0);
        hold(3'd4, 4);
        hold(3'd1, 5);
        chk("d_req", {31'd0, bus.move_req}, 32'd1);
        ack = 1; done = 1; chg = 0; step();
        ack = 0; done = 0;

        // Random stimulus against the model
        rand_moves = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 12) dir = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 3) go = ~go;
            ack  = ($urandom_range(0, 2) == 0);
            done = ($urandom_range(0, 3) == 0);
            chg  = 1'($urandom_range(0, 1));
            sd   = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 999) < 3) begin
                rst = 1'b1;
                model_reset();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
            if (m_inreq && bus.move_req) rand_moves++;
        end
        chk("rand_moves_seen", {31'd0, (rand_moves > 0)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
